// File: rtl/activation_cache_mc.sv
// Multi-channel dilated activation cache. Keeps a per-channel ring of past
// input vectors and, for each accepted vector, registers the K-tap causal
// window (spacing = runtime dilation) for every channel toward the conv MAC.
module activation_cache_mc #(
   parameter int unsigned W                = 16,
   parameter int unsigned C                = 4,
   parameter int unsigned K                = 4,
   parameter int unsigned MAX_DILATION     = 8,
   parameter int unsigned DEFAULT_DILATION = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [$clog2(MAX_DILATION+1)-1:0] dil_cfg,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [C*W-1:0]                    in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [C*K*W-1:0]                  out_taps,
   output logic                              out_primed
);

   localparam int unsigned DW    = $clog2(MAX_DILATION+1);
   localparam int unsigned SPAN  = (K-1)*MAX_DILATION;
   localparam int unsigned AW    = $clog2(SPAN+1);
   localparam int unsigned DEPTH = 1 << AW;

   logic [C*W-1:0]   r_ring [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_fill;
   logic [DW-1:0]    r_dil;
   logic             r_out_valid;
   logic             r_out_primed;
   logic [C*K*W-1:0] r_out_taps;

   logic             w_accept;
   logic [DW-1:0]    w_dil_clamped;
   logic [AW-1:0]    w_span_d;
   logic [AW-1:0]    w_back;
   logic [C*K*W-1:0] w_taps;

   assign in_ready   = !flush && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign out_valid  = r_out_valid;
   assign out_primed = r_out_primed;
   assign out_taps   = r_out_taps;
   assign w_span_d   = AW'(K-1) * AW'(r_dil);

   // Clamp the requested dilation into 1..MAX_DILATION
   always_comb begin
      w_dil_clamped = dil_cfg;
      if (dil_cfg == '0) begin
         w_dil_clamped = DW'(1);
      end else if (dil_cfg > DW'(MAX_DILATION)) begin
         w_dil_clamped = DW'(MAX_DILATION);
      end
   end

   // Assemble the dilated window; taps reaching past recorded history read as zero
   always_comb begin
      w_taps = '0;
      w_back = '0;
      for (int k = 0; k < K; k++) begin
         w_back = AW'(K-1-k) * AW'(r_dil);
         if (k == K-1) begin
            w_taps[k*C*W +: C*W] = in_data;
         end else if (w_back <= r_fill) begin
            w_taps[k*C*W +: C*W] = r_ring[r_head - w_back];
         end
      end
   end

   // Ring storage: contents need no reset, fill-based masking hides stale entries
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_ring[r_head] <= in_data;
      end
   end

   // Control state and registered output window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head       <= '0;
         r_fill       <= '0;
         r_dil        <= DW'(DEFAULT_DILATION);
         r_out_valid  <= 1'b0;
         r_out_primed <= 1'b0;
         r_out_taps   <= '0;
      end else if (flush) begin
         r_head       <= '0;
         r_fill       <= '0;
         r_dil        <= w_dil_clamped;
         r_out_valid  <= 1'b0;
         r_out_primed <= 1'b0;
      end else if (w_accept) begin
         r_out_taps   <= w_taps;
         r_head       <= r_head + AW'(1);
         if (r_fill != AW'(SPAN)) begin
            r_fill <= r_fill + AW'(1);
         end
         r_out_valid  <= 1'b1;
         r_out_primed <= (r_fill >= w_span_d);
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_activation_cache_mc.sv
// Directed bench for activation_cache_mc with C=2: ramp streams (ch0=n, ch1=-n)
// whose expected windows are computed from the ramp index and dilation.
module tb_activation_cache_mc;

   localparam int unsigned W  = 16;
   localparam int unsigned C  = 2;
   localparam int unsigned K  = 4;
   localparam int unsigned TW = C*K*W;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [3:0]    dil_cfg;
   logic          in_valid;
   logic          in_ready;
   logic [C*W-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_taps;
   logic          out_primed;

   int n_cmp;
   int n_err;

   activation_cache_mc #(
      .W(W), .C(C), .K(K), .MAX_DILATION(8), .DEFAULT_DILATION(4)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .dil_cfg(dil_cfg),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_taps(out_taps),
      .out_primed(out_primed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected window for ramp sample n (ramp restarted at 1) with dilation d
   function automatic logic [TW-1:0] win(input int n, input int d);
      logic [TW-1:0] v;
      int s;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         s = n - (3-k)*d;
         if (s >= 1) begin
            v[(k*2)*16 +: 16]   = 16'(s);
            v[(k*2+1)*16 +: 16] = 16'(-s);
         end
      end
      return v;
   endfunction

   task automatic push(input int n, input int d);
      in_data  = {16'(-n), 16'(n)};
      in_valid = 1'b1;
      #1;
      check($sformatf("in_ready n=%0d", n), TW'(in_ready), TW'(1));
      @(posedge clk); #1;
      check($sformatf("taps n=%0d d=%0d", n, d), out_taps, win(n, d));
      check($sformatf("valid n=%0d", n), TW'(out_valid), TW'(1));
      check($sformatf("primed n=%0d d=%0d", n, d), TW'(out_primed), TW'((n-1) >= 3*d));
   endtask

   task automatic do_flush(input logic [3:0] cfg);
      in_data  = {16'(-99), 16'(99)};
      in_valid = 1'b1;
      flush    = 1'b1;
      dil_cfg  = cfg;
      #1;
      check("in_ready during flush", TW'(in_ready), TW'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      check("valid after flush", TW'(out_valid), TW'(0));
      check("primed after flush", TW'(out_primed), TW'(0));
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      clk       = 1'b0;
      rst       = 1'b0;
      flush     = 1'b0;
      dil_cfg   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #1;
      check("reset valid", TW'(out_valid), TW'(0));
      check("reset taps", out_taps, '0);
      check("reset primed", TW'(out_primed), TW'(0));
      check("reset in_ready", TW'(in_ready), TW'(1));
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      // Warm-up then steady state across the ring wrap, default dilation 4
      for (int n = 1; n <= 53; n++) push(n, 4);

      // Backpressure: hold out_ready low for three cycles
      out_ready = 1'b0;
      in_data   = {16'(-54), 16'(54)};
      #1;
      check("in_ready stalled", TW'(in_ready), TW'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("stall taps %0d", i), out_taps, win(53, 4));
         check($sformatf("stall valid %0d", i), TW'(out_valid), TW'(1));
         check($sformatf("stall ready %0d", i), TW'(in_ready), TW'(0));
      end
      out_ready = 1'b1;
      for (int n = 54; n <= 56; n++) push(n, 4);

      // Flush to dilation 2 mid-stream
      do_flush(4'd2);
      for (int n = 1; n <= 7; n++) push(n, 2);

      // Clamp low: 0 behaves as 1
      do_flush(4'd0);
      for (int n = 1; n <= 4; n++) push(n, 1);

      // Clamp high: 15 behaves as 8
      do_flush(4'd15);
      for (int n = 1; n <= 25; n++) push(n, 8);

      // Async reset while output is held under backpressure
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      check("held before reset", TW'(out_valid), TW'(1));
      #2;
      rst = 1'b0;
      #1;
      check("async reset valid", TW'(out_valid), TW'(0));
      check("async reset taps", out_taps, '0);
      check("async reset primed", TW'(out_primed), TW'(0));
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int n = 1; n <= 13; n++) push(n, 4);

      in_valid = 1'b0;
      @(posedge clk); #1;
      check("idle drop valid", TW'(out_valid), TW'(0));
      check("idle hold taps", out_taps, win(13, 4));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
